// File: rtl/sqrt_iter.sv
// rtl/sqrt_iter.sv - handshaked restoring integer square root, one root bit per clock; optional rounding via SQRT_ROUND_EN
module sqrt_iter #(
  parameter int WIDTH     = 32,
  parameter int SIGNED_IN = 0
) (
  input  logic                 sqrt_clk,
  input  logic                 sqrt_rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH/2-1:0]   Out,
  output logic [WIDTH/2:0]     rem,
  output logic                 neg_err,
  output logic                 busy
);

  localparam int H  = WIDTH / 2;
  localparam int CW = (H > 1) ? $clog2(H) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [WIDTH-1:0] sreg;   // radicand, consumed two bits per step from the top
  logic [H-1:0]    q;       // partial root
  logic [H+1:0]    r;       // partial remainder, two guard bits wide
  logic [CW-1:0]   cnt;     // iterations left after the current one

  logic [H+1:0]    r_sh;
  logic [H+1:0]    t;
  logic [H+1:0]    r_nx;
  logic [H-1:0]    q_nx;
  logic [H-1:0]    out_fin;
  logic            neg_in;

  assign neg_in = (SIGNED_IN != 0) && A[WIDTH-1];

  // One restoring step: bring down the next bit pair and try subtracting 4Q+1
  always_comb begin
    r_sh = (H+2)'({r, sreg[WIDTH-1 -: 2]});
    t    = {q, 2'b01};
    if (r_sh >= t) begin
      r_nx = r_sh - t;
      q_nx = {q[H-2:0], 1'b1};
    end else begin
      r_nx = r_sh;
      q_nx = {q[H-2:0], 1'b0};
    end
  end

`ifdef SQRT_ROUND_EN
  // Round to nearest: A > Q^2 + Q exactly when the floor remainder exceeds Q; saturate at all ones
  always_comb begin
    if ((r_nx > {2'b00, q_nx}) && !(&q_nx)) begin
      out_fin = q_nx + 1'b1;
    end else begin
      out_fin = q_nx;
    end
  end
`else
  assign out_fin = q_nx;
`endif

  // Control FSM with registered handshake outputs and result registers
  always_ff @(posedge sqrt_clk) begin
    if (!sqrt_rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      Out       <= '0;
      rem       <= '0;
      neg_err   <= 1'b0;
      cnt       <= '0;
      sreg      <= '0;
      q         <= '0;
      r         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (neg_in) begin
              // Negative operand: skip the iterations and flag it
              state     <= DONE;
              out_valid <= 1'b1;
              Out       <= '0;
              rem       <= '0;
              neg_err   <= 1'b1;
            end else begin
              state   <= CALC;
              sreg    <= A;
              q       <= '0;
              r       <= '0;
              cnt     <= CW'(H - 1);
              neg_err <= 1'b0;
            end
          end
        end
        CALC: begin
          sreg <= {sreg[WIDTH-3:0], 2'b00};
          r    <= r_nx;
          q    <= q_nx;
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            Out       <= out_fin;
            rem       <= r_nx[H:0];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_iter.sv
// tb/tb_sqrt_iter.sv - self-checking bench for sqrt_iter (vector table, random ops vs arithmetic model, stall/reset/signed cases)
module tb_sqrt_iter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a_in;
  logic        out_ready;
  logic        sel;

  logic        u_in_ready, u_out_valid, u_neg_err, u_busy;
  logic [15:0] u_out;
  logic [16:0] u_rem;
  logic        s_in_ready, s_out_valid, s_neg_err, s_busy;
  logic [15:0] s_out;
  logic [16:0] s_rem;

  logic        in_ready, out_valid, neg_err, busy;
  logic [15:0] out_v;
  logic [16:0] rem_v;

  int n_checks = 0;
  int n_errors = 0;

  sqrt_iter #(.WIDTH(32), .SIGNED_IN(0)) dut (
    .sqrt_clk(clk), .sqrt_rst_n(rst_n), .in_valid(in_valid), .in_ready(u_in_ready),
    .A(a_in), .out_valid(u_out_valid), .out_ready(out_ready), .Out(u_out),
    .rem(u_rem), .neg_err(u_neg_err), .busy(u_busy)
  );

  sqrt_iter #(.WIDTH(32), .SIGNED_IN(1)) dut_s (
    .sqrt_clk(clk), .sqrt_rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .A(a_in), .out_valid(s_out_valid), .out_ready(out_ready), .Out(s_out),
    .rem(s_rem), .neg_err(s_neg_err), .busy(s_busy)
  );

  assign in_ready  = sel ? s_in_ready  : u_in_ready;
  assign out_valid = sel ? s_out_valid : u_out_valid;
  assign neg_err   = sel ? s_neg_err   : u_neg_err;
  assign busy      = sel ? s_busy      : u_busy;
  assign out_v     = sel ? s_out       : u_out;
  assign rem_v     = sel ? s_rem       : u_rem;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [15:0] exp_out;
    logic [16:0] exp_rem;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: floor root from real sqrt corrected by integer squaring, rounding by nearest-integer rule
  task automatic ref_sqrt(input logic [31:0] a, output logic [15:0] o, output logic [16:0] rm);
    longint unsigned av;
    longint unsigned rt;
    av = 64'(a);
    rt = longint'($sqrt(real'(av)));
    while (rt * rt > av) rt--;
    while ((rt + 1) * (rt + 1) <= av) rt++;
    rm = 17'(av - rt * rt);
    o  = 16'(rt);
`ifdef SQRT_ROUND_EN
    if ((av - rt * rt) > rt && rt != 64'hFFFF) o = 16'(rt + 1);
`endif
  endtask

  // One operand through the selected DUT; in_valid stays high through CALC/DONE to show it is ignored
  task automatic do_op(input string name, input logic [31:0] a, input logic [15:0] eo,
                       input logic [16:0] er, input logic en, input int exp_lat, input int stall);
    int lat;
    @(negedge clk);
    check({name, " in_ready"}, {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    a_in     = a;
    @(posedge clk);
    @(negedge clk);
    a_in = $urandom;
    lat  = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " Out"}, 64'(out_v), 64'(eo));
    check({name, " rem"}, 64'(rem_v), 64'(er));
    check({name, " neg_err"}, 64'(neg_err), 64'(en));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({name, " stall hold"}, 64'({out_valid, in_ready, busy, neg_err, out_v, rem_v}),
            64'({1'b1, 1'b0, 1'b1, en, eo, er}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({name, " release"}, 64'({out_valid, busy, in_ready}), 64'(3'b001));
  endtask

  vec_t vecs[6];
  logic [15:0] mo;
  logic [16:0] mr;
  logic [31:0] ra;
  logic        saw_valid;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a_in = '0; out_ready = 1'b0; sel = 1'b0;

`ifdef SQRT_ROUND_EN
    vecs[0] = '{32'd144, 16'd12, 17'd0};
    vecs[1] = '{32'd0, 16'd0, 17'd0};
    vecs[2] = '{32'd1, 16'd1, 17'd0};
    vecs[3] = '{32'hFFFFFFFF, 16'hFFFF, 17'h1FFFE};
    vecs[4] = '{32'd13, 16'd4, 17'd4};
    vecs[5] = '{32'd150, 16'd12, 17'd6};
`else
    vecs[0] = '{32'd144, 16'd12, 17'd0};
    vecs[1] = '{32'd0, 16'd0, 17'd0};
    vecs[2] = '{32'd1, 16'd1, 17'd0};
    vecs[3] = '{32'hFFFFFFFF, 16'hFFFF, 17'h1FFFE};
    vecs[4] = '{32'd13, 16'd3, 17'd4};
    vecs[5] = '{32'd150, 16'd12, 17'd6};
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset state", 64'({in_ready, out_valid, busy, neg_err, out_v, rem_v}),
          64'({1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 17'd0}));

    foreach (vecs[i]) do_op("vec", vecs[i].a, vecs[i].exp_out, vecs[i].exp_rem, 1'b0, 16, 0);

    for (int i = 0; i < 30; i++) begin
      case (i % 3)
        0: ra = $urandom;
        1: ra = $urandom_range(0, 1000);
        default: begin
          ra = 32'($urandom_range(1, 65535));
          ra = ra * ra - 32'($urandom_range(0, 1));
        end
      endcase
      ref_sqrt(ra, mo, mr);
      do_op("random", ra, mo, mr, 1'b0, 16, 0);
    end

    // Stalled consumer: A=170 -> 13 rem 1 (no rounding since 1 <= 13)
    do_op("stall170", 32'd170, 16'd13, 17'd1, 1'b0, 16, 10);

    // Reset at cycle 7 of CALC discards the operation
    @(negedge clk);
    in_valid = 1'b1;
    a_in     = 32'd99999;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("mid-calc busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid-calc reset", 64'({in_ready, out_valid, busy, neg_err, out_v, rem_v}),
          64'({1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 17'd0}));
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("no valid after reset", 64'(saw_valid), 64'd0);
    do_op("after reset", 32'd25, 16'd5, 17'd0, 1'b0, 16, 0);

    // Signed instance: realign both DUTs, then negative and positive operands
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sel   = 1'b1;
    do_op("signed neg", 32'h80000010, 16'd0, 17'd0, 1'b1, 0, 3);
    do_op("signed pos", 32'h00000019, 16'd5, 17'd0, 1'b0, 16, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
